// File: rtl/jacobian_mult_bank.sv
// jacobian_mult_bank: shares LANES saturating Q9.18 multipliers across a 6x6 element-wise product.
// An operand snapshot is taken on start; a two-stage pipeline multiplies one group per cycle, then saturates and writes it back.
module jacobian_mult_bank #(
    parameter int W     = 27,
    parameter int FRAC  = 18,
    parameter int LANES = 6
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     start,
    input  logic [5:0][5:0][W-1:0]   dataa,
    input  logic [5:0][5:0][W-1:0]   datab,
    output logic [5:0][5:0][W-1:0]   result,
    output logic                     busy,
    output logic                     done
);
    localparam int G = 36 / LANES;
    localparam logic signed [2*W-1:0] MAXV = {{(W+1){1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [2*W-1:0] MINV = {{(W+1){1'b1}}, {(W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FIN} state_t;

    state_t                  state, state_nx;
    logic [5:0]              grp, ptag;
    logic                    pv;
    logic [35:0][W-1:0]      abuf, bbuf, res;
    logic signed [2*W-1:0]   prod [LANES];
    logic [5:0]              iss_idx [LANES];
    logic [5:0]              wb_idx [LANES];

    function automatic logic signed [2*W-1:0] sx(input logic [W-1:0] v);
        return {{W{v[W-1]}}, v};
    endfunction

    function automatic logic [W-1:0] sat(input logic signed [2*W-1:0] p);
        logic signed [2*W-1:0] q;
        q = p >>> FRAC;
        return q > MAXV ? {1'b0, {(W-1){1'b1}}} : q < MINV ? {1'b1, {(W-1){1'b0}}} : q[W-1:0];
    endfunction

    assign result = res;
    assign busy   = state != IDLE;
    assign done   = state == FIN;

    always_comb begin
        state_nx = state == IDLE  ? (start ? ISSUE : IDLE) :
                   state == ISSUE ? (grp == 6'(G-1) ? DRAIN : ISSUE) :
                   state == DRAIN ? FIN : IDLE;
        for (int l = 0; l < LANES; l++) begin
            iss_idx[l] = 6'(int'(grp) * LANES + l);
            wb_idx[l]  = 6'(int'(ptag) * LANES + l);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            grp   <= '0;
            ptag  <= '0;
            pv    <= 1'b0;
            abuf  <= '0;
            bbuf  <= '0;
            res   <= '0;
            for (int l = 0; l < LANES; l++) prod[l] <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && start) begin
                abuf <= dataa;
                bbuf <= datab;
                grp  <= '0;
            end else if (state == ISSUE) begin
                grp <= grp + 6'd1;
            end
            pv <= state == ISSUE;
            if (state == ISSUE) ptag <= grp;
            // stage 1 multiplies the current group while stage 2 retires the previous one
            for (int l = 0; l < LANES; l++) begin
                if (state == ISSUE) prod[l] <= sx(abuf[iss_idx[l]]) * sx(bbuf[iss_idx[l]]);
                if (pv) res[wb_idx[l]] <= sat(prod[l]);
            end
        end
    end
endmodule

// File: tb/tb_jacobian_mult_bank.sv
// tb_jacobian_mult_bank: randomized operations checked every cycle against a behavioural timing/arithmetic model,
// plus literal checks of latency, saturation, back-to-back spacing, reset and a LANES sweep.
module tb_jacobian_mult_bank;
    localparam int W  = 27;
    localparam int MG = 6;

    logic clk = 1'b0, reset_n = 1'b0, start = 1'b0;
    logic [35:0][W-1:0] da = '0, db = '0;
    logic [35:0][W-1:0] res_v [4];
    logic busy_v [4];
    logic done_v [4];
    int total = 0, bad = 0;
    bit chk_on = 1'b0;

    always #5 clk = ~clk;

    for (genvar i = 0; i < 4; i++) begin : g_dut
        jacobian_mult_bank #(.W(W), .FRAC(18), .LANES(i == 0 ? 6 : i == 1 ? 1 : i == 2 ? 4 : 36)) dut (
            .clk(clk), .reset_n(reset_n), .start(start), .dataa(da), .datab(db),
            .result(res_v[i]), .busy(busy_v[i]), .done(done_v[i]));
    end

    function automatic logic [W-1:0] mref(input logic [W-1:0] a, input logic [W-1:0] b);
        longint p, q;
        p = longint'($signed(a)) * longint'($signed(b));
        q = p >>> 18;
        if (q > 64'sd67108863) return 27'h3FFFFFF;
        if (q < -64'sd67108864) return 27'h4000000;
        return q[W-1:0];
    endfunction

    function automatic logic [W-1:0] rnd();
        logic [31:0] r;
        r = $urandom;
        return r[0] ? r[W-1:0] : {{6{r[21]}}, r[21:1]};
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    task automatic scramble();
        for (int e = 0; e < 36; e++) begin
            da[e] = rnd();
            db[e] = rnd();
        end
    endtask

    // model of the LANES=6 instance: k counts edges since acceptance, -1 when idle
    logic [W-1:0] ma [36], mb [36], exp_res [36];
    int k;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            k <= -1;
            for (int e = 0; e < 36; e++) exp_res[e] <= '0;
        end else if (k < 0) begin
            if (start) begin
                for (int e = 0; e < 36; e++) begin
                    ma[e] <= da[e];
                    mb[e] <= db[e];
                end
                k <= 0;
            end
        end else begin
            if (k >= 1 && k <= MG)
                for (int l = 0; l < 6; l++) exp_res[(k-1)*6+l] <= mref(ma[(k-1)*6+l], mb[(k-1)*6+l]);
            k <= k == MG + 1 ? -1 : k + 1;
        end
    end

    always @(negedge clk) begin
        int bad_e;
        if (chk_on) begin
            bad_e = -1;
            for (int e = 35; e >= 0; e--) if (res_v[0][e] !== exp_res[e]) bad_e = e;
            chk("busy", 64'(busy_v[0]), 64'(k >= 0));
            chk("done", 64'(done_v[0]), 64'(k == MG + 1));
            total++;
            if (bad_e >= 0) begin
                bad++;
                $display("FAIL result[%0d] got=%h want=%h", bad_e, res_v[0][bad_e], exp_res[bad_e]);
            end
        end
    end

    task automatic run_op(input logic [35:0][W-1:0] a, input logic [35:0][W-1:0] b, output int lat);
        @(negedge clk);
        da = a;
        db = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        scramble();
        lat = -1;
        for (int n = 1; n <= 60; n++) begin
            @(negedge clk);
            if (done_v[0]) begin
                lat = n;
                break;
            end
            scramble();
        end
        if (lat < 0) chk("done_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        logic [35:0][W-1:0] a, b;
        int lat;
        int lats [4];
        int dc, nm;
        int dt [$];
        repeat (3) @(negedge clk);
        chk("reset_busy", 64'(busy_v[0]), 64'd0);
        chk("reset_done", 64'(done_v[0]), 64'd0);
        chk("reset_result_or", 64'(|res_v[0]), 64'd0);
        chk_on = 1'b1;
        #2 reset_n = 1'b1;

        // identity across all four LANES settings
        @(negedge clk);
        for (int e = 0; e < 36; e++) begin
            da[e] = 27'h0040000;
            db[e] = W'((e + 1) << 18);
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        scramble();
        lats = '{-1, -1, -1, -1};
        for (int n = 1; n <= 45; n++) begin
            @(negedge clk);
            scramble();
            for (int i = 0; i < 4; i++) if (done_v[i] && lats[i] < 0) lats[i] = n;
        end
        chk("ident_lat_L6", 64'(lats[0]), 64'd7);
        chk("ident_lat_L1", 64'(lats[1]), 64'd37);
        chk("ident_lat_L4", 64'(lats[2]), 64'd10);
        chk("ident_lat_L36", 64'(lats[3]), 64'd2);
        for (int i = 0; i < 4; i++) begin
            nm = 0;
            for (int e = 0; e < 36; e++) if (res_v[i][e] !== W'((e + 1) << 18)) nm++;
            chk($sformatf("ident_mismatches_inst%0d", i), 64'(nm), 64'd0);
        end

        // sign and value
        a = '0;
        b = '0;
        a[0] = 27'h0060000; b[0] = 27'h0080000;
        a[35] = 27'h7FC0000; b[35] = 27'h0020000;
        run_op(a, b, lat);
        chk("sign_lat", 64'(lat), 64'd7);
        chk("sign_e0", 64'(res_v[0][0]), 64'h00C0000);
        chk("sign_e35", 64'(res_v[0][35]), 64'h7FE0000);
        chk("sign_e17", 64'(res_v[0][17]), 64'h0);

        // saturation and truncation
        for (int e = 0; e < 36; e++) begin
            a[e] = rnd();
            b[e] = rnd();
        end
        a[0] = 27'h3200000; b[0] = 27'h0080000;
        a[1] = 27'h4E00000; b[1] = 27'h0080000;
        a[2] = 27'h0000001; b[2] = 27'h0020000;
        a[3] = 27'h7FFFFFF; b[3] = 27'h0020000;
        run_op(a, b, lat);
        chk("sat_pos", 64'(res_v[0][0]), 64'h3FFFFFF);
        chk("sat_neg", 64'(res_v[0][1]), 64'h4000000);
        chk("trunc_pos", 64'(res_v[0][2]), 64'h0);
        chk("trunc_neg", 64'(res_v[0][3]), 64'h7FFFFFF);

        // random operations
        for (int t = 0; t < 8; t++) begin
            for (int e = 0; e < 36; e++) begin
                a[e] = rnd();
                b[e] = rnd();
            end
            run_op(a, b, lat);
            chk("rand_lat", 64'(lat), 64'd7);
        end

        // start held high: acceptances every 9 cycles
        @(negedge clk);
        start = 1'b1;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            scramble();
            if (done_v[0]) dt.push_back(n);
        end
        start = 1'b0;
        repeat (12) @(negedge clk);
        chk("b2b_count", 64'(dt.size()), 64'd5);
        for (int i = 1; i < dt.size(); i++) chk("b2b_spacing", 64'(dt[i] - dt[i-1]), 64'd9);

        // reset mid-operation
        @(negedge clk);
        scramble();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("midrst_busy", 64'(busy_v[0]), 64'd0);
        chk("midrst_done", 64'(done_v[0]), 64'd0);
        chk("midrst_result_or", 64'(|res_v[0]), 64'd0);
        repeat (2) @(negedge clk);
        #2 reset_n = 1'b1;
        dc = 0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (done_v[0]) dc++;
        end
        chk("midrst_no_done", 64'(dc), 64'd0);
        for (int e = 0; e < 36; e++) begin
            a[e] = rnd();
            b[e] = rnd();
        end
        run_op(a, b, lat);
        chk("post_rst_lat", 64'(lat), 64'd7);
        repeat (4) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
